// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer
// Walks a square feature map in non-overlapping 2x2 windows. Each window is
// fetched from the input buffer (four reads), handed to the pooling core via
// a level start/finish handshake, and the pooled pixel is written to the
// output buffer. POOL and CLEAR waits are bounded by a timeout that aborts
// the frame and raises a sticky error flag.
module pool_window_sequencer #(
    parameter int IMG_SIZE = 28,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [4*DATA_W-1:0] win_out,
    output logic                pool_start,
    input  logic                pool_finish,
    input  logic [DATA_W-1:0]   pool_pixel,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data
);

    // Wait counter must be able to hold TIMEOUT-1 (TIMEOUT >= 1).
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] EDGE      = ADDR_W'(IMG_SIZE);
    localparam logic [ADDR_W-1:0] LAST_POS  = ADDR_W'(IMG_SIZE - 2);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_POOL,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]        r_fetch_cnt;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_out_idx;
    logic [WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0] r_pixel;
    logic              r_error;

    logic              w_accept;
    logic              w_last_win;
    logic              w_wait_expired;
    logic              w_advance;
    logic              w_busy;
    logic              w_done;
    logic              w_rd_en;
    logic              w_pool_start;
    logic              w_wr_en;
    logic              w_set_error;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_accept       = (r_state == S_IDLE) && start;
    assign w_last_win     = (r_row == LAST_POS) && (r_col == LAST_POS);
    assign w_wait_expired = (r_wait == WAIT_LAST);
    // Leaving CLEAR for another window (not the last one).
    assign w_advance      = (r_state == S_CLEAR) && !pool_finish && !w_last_win;
    // Top-left pixel address of the current window.
    assign w_base         = r_row * EDGE + r_col;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and control strobes.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_rd_en      = 1'b0;
        w_pool_start = 1'b0;
        w_wr_en      = 1'b0;
        w_set_error  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Reads on f=0..3; f=4 only captures the last returned pixel.
                w_rd_en = (r_fetch_cnt != 3'd4);
                if (r_fetch_cnt == 3'd4) begin
                    w_state_next = S_POOL;
                end
            end
            S_POOL: begin
                w_pool_start = 1'b1;
                if (pool_finish) begin
                    w_state_next = S_WRITE;
                end else if (w_wait_expired) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                w_wr_en      = 1'b1;
                w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                // Core must drop finish before the next window may start.
                if (!pool_finish) begin
                    w_state_next = w_last_win ? S_DONE : S_FETCH;
                end else if (w_wait_expired) begin
                    w_set_error  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Read address for the four window pixels, zero when not reading.
    always_comb begin
        w_rd_addr = '0;
        if (w_rd_en) begin
            case (r_fetch_cnt[1:0])
                2'd0:    w_rd_addr = w_base;
                2'd1:    w_rd_addr = w_base + ONE;
                2'd2:    w_rd_addr = w_base + EDGE;
                default: w_rd_addr = w_base + EDGE + ONE;
            endcase
        end
    end

    // Fetch sub-counter runs only while in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (r_state == S_FETCH) begin
            r_fetch_cnt <= r_fetch_cnt + 3'd1;
        end else begin
            r_fetch_cnt <= '0;
        end
    end

    // Wait counter: cleared outside POOL/CLEAR, so it restarts on each entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if ((r_state == S_POOL) || (r_state == S_CLEAR)) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // Window position and output index; step in raster order of windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_out_idx <= '0;
        end else if (w_accept) begin
            r_row     <= '0;
            r_col     <= '0;
            r_out_idx <= '0;
        end else if (w_advance) begin
            r_out_idx <= r_out_idx + ONE;
            if (r_col == LAST_POS) begin
                r_col <= '0;
                r_row <= r_row + STEP;
            end else begin
                r_col <= r_col + STEP;
            end
        end
    end

    // Latch the core result on the first finish seen in POOL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel <= '0;
        end else if ((r_state == S_POOL) && pool_finish) begin
            r_pixel <= pool_pixel;
        end
    end

    // Sticky timeout flag, cleared only by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_set_error) begin
            r_error <= 1'b1;
        end
    end

    // Window slots: slot gi captures read data on fetch step gi+1, because
    // the buffer returns data one cycle after the read strobe.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [DATA_W-1:0] r_slot;

            // Capture one window pixel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot <= '0;
                end else if ((r_state == S_FETCH) && (r_fetch_cnt == 3'(gi + 1))) begin
                    r_slot <= rd_data;
                end
            end

            assign win_out[gi*DATA_W +: DATA_W] = r_slot;
        end
    endgenerate

    assign busy       = w_busy;
    assign done       = w_done;
    assign error      = r_error;
    assign rd_en      = w_rd_en;
    assign rd_addr    = w_rd_addr;
    assign pool_start = w_pool_start;
    assign wr_en      = w_wr_en;
    assign wr_addr    = w_wr_en ? r_out_idx : '0;
    assign wr_data    = r_pixel;

endmodule

// File: doc/pool_window_sequencer.md
# pool_window_sequencer

Controller that walks a square feature map in non-overlapping 2x2 windows. For each window it fetches the four pixels from an input buffer and presents them to the 2x2 pooling core. It then runs the core's level start/finish handshake and writes the pooled pixel to an output buffer. It sits between the feature-map RAMs and the pooling datapath, turning one frame-level `start` into a full pooled output map.

## Interface

Parameters:
- `IMG_SIZE`, 28: input map edge length in pixels; even, 2..254; row-major, address = row*IMG_SIZE+col.
- `DATA_W`, 16: pixel width.
- `ADDR_W`, 16: read/write address width.
- `TIMEOUT`, 255: maximum cycles spent waiting in POOL or CLEAR before abort.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  frame start request; sampled in IDLE only.
- `busy`  out  1  high from the cycle after start is accepted through DONE inclusive.
- `done`  out  1  one-cycle pulse in DONE after a complete frame.
- `error`  out  1  sticky timeout flag; cleared when the next start is accepted.
- `rd_en`  out  1  input buffer read strobe.
- `rd_addr`  out  ADDR_W  input buffer address.
- `rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `rd_en`.
- `win_out`  out  4*DATA_W  window to core; slices low→high: top-left, top-right, bottom-left, bottom-right.
- `pool_start`  out  1  level start to pooling core.
- `pool_finish`  in  1  level finish from core.
- `pool_pixel`  in  DATA_W  core result; valid while `pool_finish`=1.
- `wr_en`  out  1  output buffer write strobe.
- `wr_addr`  out  ADDR_W  output index = (row/2)*(IMG_SIZE/2)+col/2.
- `wr_data`  out  DATA_W  pooled pixel.

## Operation

- Reset: state IDLE. The following are 0: row/col/out_idx counters, `busy`, `done`, `error`, `rd_en`, `rd_addr`, `win_out`, `pool_start`, `wr_en`, `wr_addr`, `wr_data`. `rst` overrides everything, including mid-frame; no write is issued after a reset cycle.
- IDLE: when `start`=1, clear `error`, zero row/col/out_idx, and go to FETCH.
- FETCH: uses a sub-counter f from 0 to 4.
  - For f=0..3: `rd_en`=1, with `rd_addr` = r*S+c, r*S+c+1, (r+1)*S+c, (r+1)*S+c+1 respectively.
  - For f=1..4: capture `rd_data` into window slot f-1.
  - After f=4, go to POOL.
- POOL: hold `pool_start`=1 and keep `win_out` stable. On the first cycle with `pool_finish`=1, latch `pool_pixel` and go to WRITE.
- WRITE: `wr_en`=1 with `wr_addr`=out_idx and `wr_data`=latched pixel. `pool_start`=0. Go to CLEAR.
- CLEAR: `pool_start`=0. Wait until `pool_finish`=0, then:
  - If last window (r=S-2, c=S-2), go to DONE.
  - Otherwise advance: c+=2; when c wraps past S-2, set c=0 and r+=2. Increment out_idx and go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- Timeout: a wait counter resets on entry to POOL and on entry to CLEAR. If it reaches TIMEOUT, set `error`=1, drop `pool_start`, go to IDLE without writing, and do not pulse `done`.
- `start` while busy is ignored. `start` held high across DONE→IDLE starts a new frame.
- Arithmetic: addresses are computed in ADDR_W bits. The pooled value is passed through unmodified.

## Timing

- Per window: 5 (FETCH) + P (POOL, ≥1) + 1 (WRITE) + C (CLEAR, ≥1) cycles.
- For a core with registered finish (finish rises 1 cycle after start, falls 1 cycle after start drops): P=2, C=1, giving 9 cycles per window.
- Frame latency from accepted start to `done`: 1 + (S/2)² × per-window + 1 cycles.
- `pool_finish` high on POOL entry is accepted immediately (P=1). CLEAR guarantees the core has dropped finish before the next window.
- Exactly one `wr_en` per window. Writes occur in out_idx order 0..(S/2)²-1.

## Test plan

- IMG_SIZE=4, RAM[i]=i, averaging mock core → writes (0,2),(1,4),(2,10),(3,12); `win_out` for window 0 = {5,4,1,0}; `done` pulses once; `error`=0.
- Same setup, read-address trace per window → 0,1,4,5 / 2,3,6,7 / 8,9,12,13 / 10,11,14,15, each with `rd_en`=1 for 4 cycles.
- Core never asserts finish, TIMEOUT=8 → `error`=1 after 8 POOL cycles, no `wr_en`, no `done`, returns to IDLE; next `start` clears `error`.
- Assert `rst` during the POOL state of window 2 → next cycle all outputs 0 and state IDLE; no further writes.
- `start` pulsed while busy → ignored; `start` held high → back-to-back frames, second frame's first write at out_idx 0.
- Core holds finish high 3 extra cycles after start drops → CLEAR lasts 4 cycles; single write per window; no duplicate writes.
